// File: rtl/corr_game_pkg.sv
// Shared definitions for the correlation guessing game: FSM states, scorer codes
// and the correlation score used by both the scorer and the player.
package corr_game_pkg;

  localparam int CORR_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CG_NONE   = 2'b00;
  localparam logic [1:0] CG_FIRST  = 2'b01;
  localparam logic [1:0] CG_SECOND = 2'b10;
  localparam logic [1:0] CG_BOTH   = 2'b11;

  localparam logic [1:0] CMP_FIRST_WINS  = 2'b01;
  localparam logic [1:0] CMP_SECOND_WINS = 2'b10;

  // Number of bit positions where num agrees with target; higher means closer.
  function automatic logic [3:0] cal_correlation(input logic [CORR_N-1:0] num,
                                                 input logic [CORR_N-1:0] target);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < CORR_N; i++) begin
      cnt = cnt + 4'(~(num[i] ^ target[i]));
    end
    return cnt;
  endfunction

endpackage

// File: rtl/correlation_guesser.sv
// Player side of the correlation game: issues base/flipped guess pairs and walks
// one bit per round toward the hidden target using the scorer's verdicts.
module correlation_guesser
  import corr_game_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N-1:0]             Seed_num,
  output logic                     guess_valid,
  output logic [N-1:0]             First_num,
  output logic [N-1:0]             Second_num,
  input  logic                     result_valid,
  input  logic [1:0]               Cmp,
  input  logic [1:0]               Correct_gues,
  output logic                     busy,
  output logic                     done,
  output logic                     hit,
  output logic                     error,
  output logic [N-1:0]             Found_num,
  output logic [$clog2(N+1)-1:0]   rounds
);

  localparam int K_W = $clog2(N + 1);
  localparam int T_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [N-1:0]    b;
  logic [K_W-1:0]  k;
  logic [T_W-1:0]  timer;

  logic [N-1:0]    flipped;
  logic [N-1:0]    b_upd;
  logic [K_W-1:0]  k_next;
  logic [N-1:0]    next_mask;
  logic            last_round;
  logic            cmp_legal;

  always_comb begin
    flipped    = b ^ (N'(1) << k);
    b_upd      = (Cmp == CMP_SECOND_WINS) ? flipped : b;
    k_next     = k + K_W'(1);
    next_mask  = N'(1) << k_next;
    last_round = (k == K_W'(N - 1));
    cmp_legal  = (Cmp == CMP_FIRST_WINS) || (Cmp == CMP_SECOND_WINS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      b           <= '0;
      k           <= '0;
      timer       <= '0;
      guess_valid <= 1'b0;
      First_num   <= '0;
      Second_num  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      error       <= 1'b0;
      Found_num   <= '0;
      rounds      <= '0;
    end else begin
      guess_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            b           <= Seed_num;
            k           <= '0;
            rounds      <= '0;
            done        <= 1'b0;
            hit         <= 1'b0;
            error       <= 1'b0;
            Found_num   <= '0;
            busy        <= 1'b1;
            guess_valid <= 1'b1;
            First_num   <= Seed_num;
            Second_num  <= Seed_num ^ N'(1);
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (result_valid) begin
            // An exact match from the scorer outranks the comparison bits.
            if (Correct_gues == CG_FIRST || Correct_gues == CG_BOTH) begin
              Found_num <= b;
              hit       <= 1'b1;
              rounds    <= rounds + K_W'(1);
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end else if (Correct_gues == CG_SECOND) begin
              Found_num <= flipped;
              hit       <= 1'b1;
              rounds    <= rounds + K_W'(1);
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end else if (!cmp_legal) begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              b      <= b_upd;
              rounds <= rounds + K_W'(1);
              if (last_round) begin
                Found_num <= b_upd;
                hit       <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_DONE;
              end else begin
                k           <= k_next;
                guess_valid <= 1'b1;
                First_num   <= b_upd;
                Second_num  <= b_upd ^ next_mask;
                state       <= ST_ISSUE;
              end
            end
          end else if (timer == T_W'(TIMEOUT)) begin
            error     <= 1'b1;
            hit       <= 1'b0;
            Found_num <= b;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end else begin
            timer <= timer + T_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_correlation_guesser.sv
// Directed bench for correlation_guesser with a behavioural one-cycle scorer.
module tb_correlation_guesser;
  import corr_game_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] Seed_num = 8'h00;
  logic       guess_valid;
  logic [7:0] First_num, Second_num;
  logic       result_valid;
  logic [1:0] Cmp, Correct_gues;
  logic       busy, done, hit, error;
  logic [7:0] Found_num;
  logic [3:0] rounds;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] target  = 8'hA5;
  logic       resp_en = 1'b1;
  int         bad_idx = -1;
  logic [1:0] bad_cmp = 2'b11;
  int         pair_cnt = 0;

  always #5 clk = ~clk;

  correlation_guesser #(.N(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .Seed_num(Seed_num),
    .guess_valid(guess_valid), .First_num(First_num), .Second_num(Second_num),
    .result_valid(result_valid), .Cmp(Cmp), .Correct_gues(Correct_gues),
    .busy(busy), .done(done), .hit(hit), .error(error),
    .Found_num(Found_num), .rounds(rounds)
  );

  // Scorer model: answers every issued pair one cycle later.
  always_ff @(posedge clk) begin
    result_valid <= resp_en && guess_valid;
    if (start) pair_cnt <= 0;
    else if (guess_valid) pair_cnt <= pair_cnt + 1;
    if (guess_valid) begin
      if (pair_cnt == bad_idx)
        Cmp <= bad_cmp;
      else
        Cmp <= {cal_correlation(First_num, target) <= cal_correlation(Second_num, target),
                cal_correlation(First_num, target) >= cal_correlation(Second_num, target)};
      Correct_gues <= {Second_num == target, First_num == target};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] seed);
    Seed_num = seed;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int i;
    i = 0;
    while (done !== 1'b1 && i < max) begin
      tick();
      i++;
    end
    ntests++;
    if (done !== 1'b1) begin
      nfail++;
      $display("FAIL %s_wait: done=%b, required 1 within %0d cycles", name, done, max);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    ntests++;
    if ({guess_valid, First_num, Second_num, busy, done, hit, error, Found_num, rounds} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: gv=%b F=%h S=%h busy=%b done=%b hit=%b err=%b found=%h rounds=%0d, required all 0",
               guess_valid, First_num, Second_num, busy, done, hit, error, Found_num, rounds);
    end
    reset = 1'b1;
    tick();
    ntests++;
    if (busy !== 1'b0 || guess_valid !== 1'b0) begin
      nfail++;
      $display("FAIL idle_no_start: busy=%b gv=%b, required 0 0", busy, guess_valid);
    end
  endtask

  task automatic test_full_search();
    target = 8'hA5; resp_en = 1'b1; bad_idx = -1;
    pulse_start(8'h00);
    ntests++;
    if (guess_valid !== 1'b1 || First_num !== 8'h00 || Second_num !== 8'h01) begin
      nfail++;
      $display("FAIL search_first_pair: gv=%b F=%h S=%h, required 1 00 01", guess_valid, First_num, Second_num);
    end
    tick(); tick();
    pulse_start(8'hFF);
    wait_done(40, "search");
    ntests++;
    if (Found_num !== 8'hA5 || hit !== 1'b1 || error !== 1'b0) begin
      nfail++;
      $display("FAIL search_result: found=%h hit=%b err=%b, required a5 1 0", Found_num, hit, error);
    end
    ntests++;
    if (rounds !== 4'd8 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL search_rounds: rounds=%0d busy=%b, required 8 0", rounds, busy);
    end
  endtask

  task automatic test_seed_is_target();
    target = 8'hA5; resp_en = 1'b1; bad_idx = -1;
    pulse_start(8'hA5);
    ntests++;
    if (guess_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || Second_num !== 8'hA4) begin
      nfail++;
      $display("FAIL seed_issue: gv=%b busy=%b done=%b S=%h, required 1 1 0 a4", guess_valid, busy, done, Second_num);
    end
    tick();
    ntests++;
    if (done !== 1'b0 || guess_valid !== 1'b0) begin
      nfail++;
      $display("FAIL seed_wait: done=%b gv=%b, required 0 0", done, guess_valid);
    end
    tick();
    ntests++;
    if (done !== 1'b1 || hit !== 1'b1 || Found_num !== 8'hA5 || rounds !== 4'd1) begin
      nfail++;
      $display("FAIL seed_hit: done=%b hit=%b found=%h rounds=%0d, required 1 1 a5 1", done, hit, Found_num, rounds);
    end
  endtask

  task automatic test_back_to_back_second();
    target = 8'hA5; resp_en = 1'b1; bad_idx = -1;
    pulse_start(8'hA4);
    ntests++;
    if (done !== 1'b0 || guess_valid !== 1'b1 || Found_num !== 8'h00) begin
      nfail++;
      $display("FAIL restart_from_done: done=%b gv=%b found=%h, required 0 1 00", done, guess_valid, Found_num);
    end
    wait_done(10, "second");
    ntests++;
    if (Found_num !== 8'hA5 || hit !== 1'b1 || rounds !== 4'd1 || error !== 1'b0) begin
      nfail++;
      $display("FAIL second_hit: found=%h hit=%b rounds=%0d err=%b, required a5 1 1 0", Found_num, hit, rounds, error);
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0; bad_idx = -1;
    pulse_start(8'h3C);
    for (int i = 0; i < 16; i++) tick();
    ntests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL timeout_early: done=%b busy=%b, required 0 1", done, busy);
    end
    tick();
    ntests++;
    if (done !== 1'b1 || error !== 1'b1 || hit !== 1'b0 || Found_num !== 8'h3C || rounds !== 4'd0) begin
      nfail++;
      $display("FAIL timeout_abort: done=%b err=%b hit=%b found=%h rounds=%0d, required 1 1 0 3c 0",
               done, error, hit, Found_num, rounds);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_bad_cmp();
    target = 8'hA5; resp_en = 1'b1;
    bad_idx = 2; bad_cmp = 2'b11;
    pulse_start(8'h00);
    wait_done(40, "cmp11");
    ntests++;
    if (error !== 1'b1 || done !== 1'b1 || rounds !== 4'd2 || Found_num !== 8'h00 || hit !== 1'b0) begin
      nfail++;
      $display("FAIL cmp11_error: err=%b done=%b rounds=%0d found=%h hit=%b, required 1 1 2 00 0",
               error, done, rounds, Found_num, hit);
    end
    bad_idx = 0; bad_cmp = 2'b00;
    pulse_start(8'h10);
    wait_done(40, "cmp00");
    ntests++;
    if (error !== 1'b1 || rounds !== 4'd0 || hit !== 1'b0) begin
      nfail++;
      $display("FAIL cmp00_error: err=%b rounds=%0d hit=%b, required 1 0 0", error, rounds, hit);
    end
    bad_idx = -1;
  endtask

  task automatic test_reset_mid_search();
    target = 8'hA5; resp_en = 1'b1; bad_idx = -1;
    pulse_start(8'h00);
    for (int i = 0; i < 7; i++) tick();
    ntests++;
    if (busy !== 1'b1 || rounds !== 4'd3 || First_num !== 8'h05 || Second_num !== 8'h0D) begin
      nfail++;
      $display("FAIL mid_round4: busy=%b rounds=%0d F=%h S=%h, required 1 3 05 0d", busy, rounds, First_num, Second_num);
    end
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    ntests++;
    if ({guess_valid, First_num, Second_num, busy, done, hit, error, Found_num, rounds} !== '0) begin
      nfail++;
      $display("FAIL mid_reset: gv=%b F=%h S=%h busy=%b done=%b hit=%b err=%b found=%h rounds=%0d, required all 0",
               guess_valid, First_num, Second_num, busy, done, hit, error, Found_num, rounds);
    end
    tick();
    ntests++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL mid_idle: busy=%b, required 0", busy);
    end
    pulse_start(8'hA4);
    wait_done(10, "rerun");
    ntests++;
    if (Found_num !== 8'hA5 || hit !== 1'b1 || rounds !== 4'd1) begin
      nfail++;
      $display("FAIL rerun_result: found=%h hit=%b rounds=%0d, required a5 1 1", Found_num, hit, rounds);
    end
  endtask

  initial begin
    test_reset();
    test_full_search();
    test_seed_is_target();
    test_back_to_back_second();
    test_timeout();
    test_bad_cmp();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
